alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the 32x32 register file and the 8-op ALU.
//  Accepts one command per valid/ready handshake: op, srcA, srcB, dst, repeat count, no-writeback flag.
//  Drives the register-file read/write addresses, Write_Reg and ALU_OP, and iterates the op cnt+1 times.
//  ALU F is wired straight to the register-file write data. Flags are collected per command and reported with a done pulse.
// PARAMETERS
//  ADDR_W  5  register address width (32 registers)
//  OP_W    3  ALU_OP width: 0 and,1 or,2 xor,3 inc,4 add,5 sub,6 slt,7 sll
//  CNT_W   4  repeat-count width; a command executes cmd_cnt+1 iterations (1..16)
// PORTS
//  clk          in   1       clock, all state on posedge
//  Reset        in   1       synchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept (IDLE and !Reset)
//  cmd_op       in   OP_W    ALU operation
//  cmd_a        in   ADDR_W  source A register
//  cmd_b        in   ADDR_W  source B register
//  cmd_dst      in   ADDR_W  destination register
//  cmd_cnt      in   CNT_W   extra iterations
//  cmd_nowb     in   1       1 = compare only, never assert Write_Reg
//  R_Addr_A     out  ADDR_W  to register file read port A
//  R_Addr_B     out  ADDR_W  to register file read port B
//  W_Addr       out  ADDR_W  to register file write address
//  Write_Reg    out  1       register-file write enable
//  ALU_OP       out  OP_W    to ALU
//  OF           in   1       ALU overflow (combinational)
//  ZF           in   1       ALU zero (combinational)
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse at command completion
//  of_sticky    out  1       OR of OF over all iterations of the last command
//  zf_last      out  1       ZF of the final iteration of the last command
// BEHAVIOUR
//  - Reset value: all address/ALU_OP outputs 0; Write_Reg, busy, done, of_sticky, zf_last 0; state IDLE.
//  - cmd_ready is 0 while Reset is high and 1 in IDLE afterwards.
//  - FSM states: IDLE -> ISSUE -> WRITE -> (ISSUE | DONE) -> IDLE.
//  - IDLE: on cmd_valid && cmd_ready, latch all cmd_* fields and load iter = cmd_cnt.
//    Clear of_sticky and zf_last, then go to ISSUE. cmd_* fields need to be stable only in the accept cycle.
//  - ISSUE: drive the latched addresses and ALU_OP with Write_Reg=0 (settle cycle).
//  - WRITE: hold the same addresses and op; Write_Reg = !nowb.
//    At the edge ending WRITE: register file captures F; of_sticky |= OF; zf_last <= ZF.
//    Then, if iter != 0: iter <= iter-1, go to ISSUE. Otherwise go to DONE.
//  - DONE: done=1 for exactly one cycle, busy stays 1; go to IDLE.
//    of_sticky and zf_last hold until the next accept.
//  - Latency: accept at edge k gives done high in cycle k + 2*(cnt+1) + 1, then IDLE next cycle.
//  - Each iteration re-reads its sources, so dst==srcA accumulates (inc/add loops). No bypass is needed.
//  - Outside ISSUE/WRITE, addresses/ALU_OP hold their last values and Write_Reg=0.
//  - Write_Reg is never high in IDLE, ISSUE or DONE, and never high when nowb=1.
//  - Commands presented while busy are not accepted; cmd_valid may stay high until ready.
//  - Reset mid-command: the next edge aborts to IDLE with outputs at reset values; no further write occurs.
//    The register file clears on the same edge.
//  - iter is CNT_W bits wide and decrements only while nonzero; no wrap.
// TESTING
//  1 After Reset, cmd op=3(inc) a=1 b=0 dst=1 cnt=4 -> 5 Write_Reg pulses; R1=5; done at accept+11; busy low after.
//  2 op=4(add) a=1 b=1 dst=2 cnt=0 -> R2=10, of_sticky=0, zf_last=0.
//  3 op=5(sub) a=2 b=2 dst=2 nowb=1 -> Write_Reg never high; zf_last=1; R2 still 10.
//  4 Build R8=30 (inc cnt=14 into R7, then add R7+R7) and R9=1 (inc a=0).
//    Then op=7 a=8 b=9 dst=10 -> R10=0x4000_0000; op=4 a=10 b=10 dst=10 -> R10=0x8000_0000, of_sticky=1.
//  5 Hold cmd_valid high with a second command during busy -> accepted only in the cycle after done; no command is lost or duplicated.
//  6 Assert Reset during WRITE of cnt=7 inc -> next cycle Write_Reg=0, busy=0, done never pulses; all registers read 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command channel into the ALU sequencer: one command per valid/ready handshake.
// master = command producer, slave = sequencer.
interface alu_cmd_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_a;
    logic [ADDR_W-1:0] cmd_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              cmd_nowb;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dst, cmd_cnt, cmd_nowb,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dst, cmd_cnt, cmd_nowb,
        output cmd_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Multi-cycle controller sequencing a 32x32 register file and 8-op ALU:
// each command runs cnt+1 ISSUE/WRITE iterations, then pulses done with collected flags.
module alu_cmd_sequencer #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    alu_cmd_sequencer_if.slave    cmd,
    output logic [ADDR_W-1:0]     R_Addr_A,
    output logic [ADDR_W-1:0]     R_Addr_B,
    output logic [ADDR_W-1:0]     W_Addr,
    output logic                  Write_Reg,
    output logic [OP_W-1:0]       ALU_OP,
    input  logic                  OF,
    input  logic                  ZF,
    output logic                  busy,
    output logic                  done,
    output logic                  of_sticky,
    output logic                  zf_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [ADDR_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                nowb_q, nowb_d;
    logic [CNT_W-1:0]    iter_q, iter_d;
    logic                of_q, of_d;
    logic                zf_q, zf_d;
    logic                ready;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            nowb_q  <= 1'b0;
            iter_q  <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            nowb_q  <= nowb_d;
            iter_q  <= iter_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        op_d      = op_q;
        nowb_d    = nowb_q;
        iter_d    = iter_q;
        of_d      = of_q;
        zf_d      = zf_q;
        Write_Reg = 1'b0;
        done      = 1'b0;
        ready     = (state_q == IDLE) && !Reset;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid && ready) begin
                    a_d     = cmd.cmd_a;
                    b_d     = cmd.cmd_b;
                    dst_d   = cmd.cmd_dst;
                    op_d    = cmd.cmd_op;
                    nowb_d  = cmd.cmd_nowb;
                    iter_d  = cmd.cmd_cnt;
                    of_d    = 1'b0;
                    zf_d    = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WRITE;
            WRITE: begin
                // The register file captures F on the edge that ends this cycle.
                Write_Reg = !nowb_q;
                of_d      = of_q | OF;
                zf_d      = ZF;
                if (iter_q != '0) begin
                    iter_d  = iter_q - 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses and op come straight from the latched command, so they hold between commands.
    assign cmd.cmd_ready = ready;
    assign R_Addr_A      = a_q;
    assign R_Addr_B      = b_q;
    assign W_Addr        = dst_q;
    assign ALU_OP        = op_q;
    assign busy          = (state_q != IDLE);
    assign of_sticky     = of_q;
    assign zf_last       = zf_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: sequencer wired to a behavioural 32x32 register file and 8-op ALU.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic        Write_Reg;
    logic [2:0]  ALU_OP;
    logic        OF, ZF;
    logic        busy, done, of_sticky, zf_last;

    logic [31:0] rf [32];
    logic [31:0] alu_a, alu_b, alu_f;

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer_if cmd_if ();

    alu_cmd_sequencer dut (
        .clk       (clk),
        .Reset     (Reset),
        .cmd       (cmd_if.slave),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .Write_Reg (Write_Reg),
        .ALU_OP    (ALU_OP),
        .OF        (OF),
        .ZF        (ZF),
        .busy      (busy),
        .done      (done),
        .of_sticky (of_sticky),
        .zf_last   (zf_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_a = rf[R_Addr_A];
        alu_b = rf[R_Addr_B];
        alu_f = '0;
        OF    = 1'b0;
        case (ALU_OP)
            3'd0: alu_f = alu_a & alu_b;
            3'd1: alu_f = alu_a | alu_b;
            3'd2: alu_f = alu_a ^ alu_b;
            3'd3: alu_f = alu_a + 32'd1;
            3'd4: begin
                alu_f = alu_a + alu_b;
                OF    = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd5: begin
                alu_f = alu_a - alu_b;
                OF    = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd6: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_f = alu_b << alu_a[4:0];
        endcase
        ZF = (alu_f == 32'd0);
    end

    always @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (Write_Reg) begin
            rf[W_Addr] <= alu_f;
        end
    end

    // Presents one command, scrambles the fields after acceptance, and counts cycles to done.
    task automatic issue_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] dst, input logic [3:0] cnt, input logic nowb,
                             output int done_cyc, output int wr_cnt);
        done_cyc = -1;
        wr_cnt   = 0;
        @(negedge clk);
        cmd_if.cmd_op    = op;
        cmd_if.cmd_a     = a;
        cmd_if.cmd_b     = b;
        cmd_if.cmd_dst   = dst;
        cmd_if.cmd_cnt   = cnt;
        cmd_if.cmd_nowb  = nowb;
        cmd_if.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_if.cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_a     = 5'($urandom);
        cmd_if.cmd_b     = 5'($urandom);
        cmd_if.cmd_dst   = 5'($urandom);
        cmd_if.cmd_cnt   = 4'($urandom);
        cmd_if.cmd_nowb  = 1'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (Write_Reg) wr_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = '0; cmd_if.cmd_a = '0; cmd_if.cmd_b = '0;
        cmd_if.cmd_dst = '0; cmd_if.cmd_cnt = '0; cmd_if.cmd_nowb = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_low: got %b want 0", cmd_if.cmd_ready);
        end
        Reset = 1'b0;
        @(negedge clk);
        total++;
        if ({R_Addr_A, R_Addr_B, W_Addr, ALU_OP} !== 18'd0) begin
            bad++; $display("FAIL reset_addr_op: got %h want 0", {R_Addr_A, R_Addr_B, W_Addr, ALU_OP});
        end
        total++;
        if ({Write_Reg, busy, done, of_sticky, zf_last} !== 5'b0) begin
            bad++; $display("FAIL reset_status: got %b want 00000", {Write_Reg, busy, done, of_sticky, zf_last});
        end
        total++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_idle: got %b want 1", cmd_if.cmd_ready);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_inc_loop();
        int dc, wc;
        issue_cmd(3'd3, 5'd1, 5'd0, 5'd1, 4'd4, 1'b0, dc, wc);
        total++;
        if (dc !== 11) begin bad++; $display("FAIL inc_done_latency: got %0d want 11", dc); end
        total++;
        if (wc !== 5) begin bad++; $display("FAIL inc_write_pulses: got %0d want 5", wc); end
        total++;
        if (rf[1] !== 32'd5) begin bad++; $display("FAIL inc_r1: got %h want 5", rf[1]); end
        @(negedge clk);
        total++;
        if ({busy, done, cmd_if.cmd_ready} !== 3'b001) begin
            bad++; $display("FAIL inc_idle_after: got busy/done/ready=%b want 001", {busy, done, cmd_if.cmd_ready});
        end
        $display("test_inc_loop: done_cyc=%0d writes=%0d R1=%0d", dc, wc, rf[1]);
    endtask

    task automatic test_add();
        int dc, wc;
        issue_cmd(3'd4, 5'd1, 5'd1, 5'd2, 4'd0, 1'b0, dc, wc);
        total++;
        if (dc !== 3) begin bad++; $display("FAIL add_done_latency: got %0d want 3", dc); end
        total++;
        if (rf[2] !== 32'd10) begin bad++; $display("FAIL add_r2: got %h want a", rf[2]); end
        total++;
        if ({of_sticky, zf_last} !== 2'b00) begin
            bad++; $display("FAIL add_flags: got of/zf=%b want 00", {of_sticky, zf_last});
        end
        $display("test_add: R2=%0d of=%b zf=%b", rf[2], of_sticky, zf_last);
    endtask

    task automatic test_nowb_compare();
        int dc, wc;
        issue_cmd(3'd5, 5'd2, 5'd2, 5'd2, 4'd0, 1'b1, dc, wc);
        total++;
        if (wc !== 0) begin bad++; $display("FAIL nowb_write_pulses: got %0d want 0", wc); end
        total++;
        if (zf_last !== 1'b1) begin bad++; $display("FAIL nowb_zf_last: got %b want 1", zf_last); end
        total++;
        if (rf[2] !== 32'd10) begin bad++; $display("FAIL nowb_r2_kept: got %h want a", rf[2]); end
        $display("test_nowb_compare: writes=%0d zf=%b R2=%0d", wc, zf_last, rf[2]);
    endtask

    task automatic test_shift_overflow();
        int dc, wc;
        issue_cmd(3'd3, 5'd7, 5'd0, 5'd7, 4'd14, 1'b0, dc, wc);
        total++;
        if (dc !== 31 || rf[7] !== 32'd15) begin
            bad++; $display("FAIL build_r7: got done=%0d R7=%h want 31/f", dc, rf[7]);
        end
        issue_cmd(3'd4, 5'd7, 5'd7, 5'd8, 4'd0, 1'b0, dc, wc);
        issue_cmd(3'd3, 5'd0, 5'd0, 5'd9, 4'd0, 1'b0, dc, wc);
        total++;
        if (rf[8] !== 32'd30 || rf[9] !== 32'd1) begin
            bad++; $display("FAIL build_r8_r9: got %h/%h want 1e/1", rf[8], rf[9]);
        end
        issue_cmd(3'd7, 5'd8, 5'd9, 5'd10, 4'd0, 1'b0, dc, wc);
        total++;
        if (rf[10] !== 32'h4000_0000) begin
            bad++; $display("FAIL sll_r10: got %h want 40000000", rf[10]);
        end
        issue_cmd(3'd4, 5'd10, 5'd10, 5'd10, 4'd0, 1'b0, dc, wc);
        total++;
        if (rf[10] !== 32'h8000_0000) begin
            bad++; $display("FAIL ovf_r10: got %h want 80000000", rf[10]);
        end
        total++;
        if ({of_sticky, zf_last} !== 2'b10) begin
            bad++; $display("FAIL ovf_flags: got of/zf=%b want 10", {of_sticky, zf_last});
        end
        $display("test_shift_overflow: R10=%h of=%b", rf[10], of_sticky);
    endtask

    task automatic test_back_to_back();
        int done1, ready_cyc, done2, wc;
        done1 = -1; ready_cyc = -1; done2 = -1; wc = 0;
        @(negedge clk);
        cmd_if.cmd_op = 3'd3; cmd_if.cmd_a = 5'd11; cmd_if.cmd_b = 5'd0;
        cmd_if.cmd_dst = 5'd11; cmd_if.cmd_cnt = 4'd1; cmd_if.cmd_nowb = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.cmd_cnt = 4'd2;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (Write_Reg) wc++;
            if (done && done1 < 0) done1 = c;
            if (cmd_if.cmd_ready) begin
                ready_cyc = c;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (Write_Reg) wc++;
            if (done) begin
                done2 = c;
                break;
            end
        end
        total++;
        if (done1 !== 5 || ready_cyc !== 6) begin
            bad++; $display("FAIL b2b_first: got done=%0d ready=%0d want 5/6", done1, ready_cyc);
        end
        total++;
        if (done2 !== 7 || wc !== 5) begin
            bad++; $display("FAIL b2b_second: got done=%0d writes=%0d want 7/5", done2, wc);
        end
        total++;
        if (rf[11] !== 32'd5) begin bad++; $display("FAIL b2b_r11: got %h want 5", rf[11]); end
        $display("test_back_to_back: done1=%0d ready=%0d done2=%0d R11=%0d", done1, ready_cyc, done2, rf[11]);
    endtask

    task automatic test_reset_abort();
        int wc, nz, dones;
        wc = 0; nz = 0; dones = 0;
        @(negedge clk);
        cmd_if.cmd_op = 3'd3; cmd_if.cmd_a = 5'd12; cmd_if.cmd_b = 5'd0;
        cmd_if.cmd_dst = 5'd12; cmd_if.cmd_cnt = 4'd7; cmd_if.cmd_nowb = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (Write_Reg) wc++;
        end
        total++;
        if (wc !== 3 || rf[12] !== 32'd2) begin
            bad++; $display("FAIL abort_pre: got writes=%0d R12=%h want 3/2", wc, rf[12]);
        end
        Reset = 1'b1;
        @(negedge clk);
        total++;
        if ({Write_Reg, busy, done, cmd_if.cmd_ready} !== 4'b0000) begin
            bad++; $display("FAIL abort_status: got wr/busy/done/ready=%b want 0000",
                            {Write_Reg, busy, done, cmd_if.cmd_ready});
        end
        total++;
        if ({R_Addr_A, W_Addr, ALU_OP} !== 13'd0) begin
            bad++; $display("FAIL abort_outputs: got %h want 0", {R_Addr_A, W_Addr, ALU_OP});
        end
        for (int i = 0; i < 32; i++) if (rf[i] !== 32'd0) nz++;
        total++;
        if (nz !== 0) begin bad++; $display("FAIL abort_rf_clear: got %0d nonzero want 0", nz); end
        Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || Write_Reg) dones++;
        end
        total++;
        if (dones !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: got done/write cycles=%0d busy=%b want 0/0", dones, busy);
        end
        $display("test_reset_abort: pre_writes=%0d nonzero_regs=%0d", wc, nz);
    endtask

    initial begin
        test_reset();
        test_inc_loop();
        test_add();
        test_nowb_compare();
        test_shift_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
